// File: rtl/spu_issue_ctrl_if.sv
// Signal bundle between decode, spu_issue_ctrl and ID_REG_STAGE.
// The controller takes the slave modport; the decode side takes master.
interface spu_issue_ctrl_if #(
    parameter int OPW  = 11,
    parameter int LATW = 3,
    parameter int RIW  = 7
);
    logic            pair_valid;
    logic            pair_ready;
    logic            flush;

    logic [OPW-1:0]  opcode_in1, opcode_in2;
    logic [RIW-1:0]  ra_in1, rb_in1, rc_in1, rt_in1;
    logic [RIW-1:0]  ra_in2, rb_in2, rc_in2, rt_in2;
    logic            use_ra_in1, use_rb_in1, use_rc_in1, wr_rt_in1;
    logic            use_ra_in2, use_rb_in2, use_rc_in2, wr_rt_in2;
    logic [LATW-1:0] lat_in1, lat_in2;

    logic [OPW-1:0]  opcode_o1, opcode_o2;
    logic [RIW-1:0]  ra_o1, rb_o1, rc_o1, rt_o1;
    logic [RIW-1:0]  ra_o2, rb_o2, rc_o2, rt_o2;
    logic            issue1, issue2, nop;

    modport master (
        output pair_valid, flush,
               opcode_in1, opcode_in2,
               ra_in1, rb_in1, rc_in1, rt_in1,
               ra_in2, rb_in2, rc_in2, rt_in2,
               use_ra_in1, use_rb_in1, use_rc_in1, wr_rt_in1,
               use_ra_in2, use_rb_in2, use_rc_in2, wr_rt_in2,
               lat_in1, lat_in2,
        input  pair_ready,
               opcode_o1, opcode_o2,
               ra_o1, rb_o1, rc_o1, rt_o1,
               ra_o2, rb_o2, rc_o2, rt_o2,
               issue1, issue2, nop
    );

    modport slave (
        input  pair_valid, flush,
               opcode_in1, opcode_in2,
               ra_in1, rb_in1, rc_in1, rt_in1,
               ra_in2, rb_in2, rc_in2, rt_in2,
               use_ra_in1, use_rb_in1, use_rc_in1, wr_rt_in1,
               use_ra_in2, use_rb_in2, use_rc_in2, wr_rt_in2,
               lat_in1, lat_in2,
        output pair_ready,
               opcode_o1, opcode_o2,
               ra_o1, rb_o1, rc_o1, rt_o1,
               ra_o2, rb_o2, rc_o2, rt_o2,
               issue1, issue2, nop
    );
endinterface

// File: rtl/spu_issue_ctrl.sv
// Dual-issue in-order issue controller: buffers one decoded pair, checks RAW/WAW
// against a per-register latency scoreboard and drives the ID_REG_STAGE enables.
module spu_issue_ctrl #(
    parameter int NREG = 128,
    parameter int LATW = 3,
    parameter int OPW  = 11
) (
    input  logic              clk,
    input  logic              reset,
    spu_issue_ctrl_if.slave   bus
);
    localparam int RIW = $clog2(NREG);

    typedef enum logic [1:0] {EMPTY, FULL, HALF} state_t;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [RIW-1:0]  ra;
        logic [RIW-1:0]  rb;
        logic [RIW-1:0]  rc;
        logic [RIW-1:0]  rt;
        logic            use_ra;
        logic            use_rb;
        logic            use_rc;
        logic            wr_rt;
        logic [LATW-1:0] lat;
    } slot_t;

    state_t          r_state, w_next;
    slot_t           r_s1, r_s2;
    slot_t           w_in1, w_in2;
    logic [LATW-1:0] r_sb [NREG];

    logic w_blk1, w_blk2, w_intra;
    logic w_issue1, w_issue2, w_ready, w_accept;

    always_comb begin
        w_in1 = '{op: bus.opcode_in1, ra: bus.ra_in1, rb: bus.rb_in1, rc: bus.rc_in1,
                  rt: bus.rt_in1, use_ra: bus.use_ra_in1, use_rb: bus.use_rb_in1,
                  use_rc: bus.use_rc_in1, wr_rt: bus.wr_rt_in1, lat: bus.lat_in1};
        w_in2 = '{op: bus.opcode_in2, ra: bus.ra_in2, rb: bus.rb_in2, rc: bus.rc_in2,
                  rt: bus.rt_in2, use_ra: bus.use_ra_in2, use_rb: bus.use_rb_in2,
                  use_rc: bus.use_rc_in2, wr_rt: bus.wr_rt_in2, lat: bus.lat_in2};
    end

    // Any nonzero countdown means the register's producer is still in flight.
    always_comb begin
        w_blk1  = (r_s1.use_ra && (r_sb[r_s1.ra] != '0)) ||
                  (r_s1.use_rb && (r_sb[r_s1.rb] != '0)) ||
                  (r_s1.use_rc && (r_sb[r_s1.rc] != '0)) ||
                  (r_s1.wr_rt  && (r_sb[r_s1.rt] != '0));
        w_blk2  = (r_s2.use_ra && (r_sb[r_s2.ra] != '0)) ||
                  (r_s2.use_rb && (r_sb[r_s2.rb] != '0)) ||
                  (r_s2.use_rc && (r_sb[r_s2.rc] != '0)) ||
                  (r_s2.wr_rt  && (r_sb[r_s2.rt] != '0));
        w_intra = r_s1.wr_rt &&
                  ((r_s2.use_ra && (r_s2.ra == r_s1.rt)) ||
                   (r_s2.use_rb && (r_s2.rb == r_s1.rt)) ||
                   (r_s2.use_rc && (r_s2.rc == r_s1.rt)) ||
                   (r_s2.wr_rt  && (r_s2.rt == r_s1.rt)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = EMPTY;
        end else if (w_accept) begin
            w_next = FULL;
        end else if ((r_state == FULL) && w_issue1 && !w_issue2) begin
            w_next = HALF;
        end else if (((r_state == FULL) || (r_state == HALF)) && w_issue2) begin
            // A fully drained buffer with nothing new arriving goes empty.
            w_next = EMPTY;
        end
    end

    always_comb begin
        w_issue1 = 1'b0;
        w_issue2 = 1'b0;
        unique case (r_state)
            FULL: begin
                w_issue1 = !w_blk1;
                w_issue2 = w_issue1 && !w_blk2 && !w_intra;
            end
            HALF:    w_issue2 = !w_blk2;
            default: ;
        endcase
        w_ready  = !bus.flush &&
                   ((r_state == EMPTY) ||
                    ((r_state == FULL) && w_issue1 && w_issue2) ||
                    ((r_state == HALF) && w_issue2));
        w_accept = bus.pair_valid && w_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_accept) begin
            r_s1 <= w_in1;
            r_s2 <= w_in2;
        end
    end

    // A load on issue overrides that register's decrement in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - LATW'(1);
                end
            end
            if (w_issue1 && r_s1.wr_rt && (r_s1.lat != '0)) begin
                r_sb[r_s1.rt] <= r_s1.lat;
            end
            if (w_issue2 && r_s2.wr_rt && (r_s2.lat != '0)) begin
                r_sb[r_s2.rt] <= r_s2.lat;
            end
        end
    end

    assign bus.pair_ready = w_ready;
    assign bus.issue1     = w_issue1;
    assign bus.issue2     = w_issue2;
    assign bus.nop        = !(w_issue1 || w_issue2);

    assign bus.opcode_o1  = r_s1.op;
    assign bus.ra_o1      = r_s1.ra;
    assign bus.rb_o1      = r_s1.rb;
    assign bus.rc_o1      = r_s1.rc;
    assign bus.rt_o1      = r_s1.rt;
    assign bus.opcode_o2  = r_s2.op;
    assign bus.ra_o2      = r_s2.ra;
    assign bus.rb_o2      = r_s2.rb;
    assign bus.rc_o2      = r_s2.rc;
    assign bus.rt_o2      = r_s2.rt;
endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Bench for spu_issue_ctrl: a queue-of-pending-instructions model with per-register
// ready-cycle bookkeeping, directed hazard scenarios and a randomized phase.
module tb_spu_issue_ctrl;
    localparam int NREG = 128;
    localparam int LATW = 3;
    localparam int OPW  = 11;

    typedef struct {
        logic [OPW-1:0]  op;
        logic [6:0]      ra, rb, rc, rt;
        logic            ua, ub, uc, wr;
        logic [LATW-1:0] lat;
    } instT;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    spu_issue_ctrl_if #(.OPW(OPW), .LATW(LATW), .RIW(7)) bus ();

    spu_issue_ctrl #(.NREG(NREG), .LATW(LATW), .OPW(OPW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: in-order pending instructions, the pair last shown on the
    // outputs, and the first cycle at which each register may be touched again.
    instT   pend[$];
    instT   shown1, shown2, zeroI;
    longint readyAt [NREG];
    longint cyc = 0;
    logic   obsI1, obsI2, obsNop, obsRdy;

    function automatic instT mk(int op, int ra, int rb, int rc, int rt,
                                bit ua, bit ub, bit uc, bit wr, int lat);
        instT x;
        x.op = OPW'(op);   x.ra = 7'(ra);  x.rb = 7'(rb);  x.rc = 7'(rc);  x.rt = 7'(rt);
        x.ua = ua;         x.ub = ub;      x.uc = uc;      x.wr = wr;      x.lat = LATW'(lat);
        return x;
    endfunction

    function automatic instT randInst();
        return mk(int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    endfunction

    function automatic logic busyM(logic [6:0] r);
        return cyc < readyAt[r];
    endfunction

    function automatic logic blockedM(instT x);
        return (x.ua && busyM(x.ra)) || (x.ub && busyM(x.rb)) ||
               (x.uc && busyM(x.rc)) || (x.wr && busyM(x.rt));
    endfunction

    function automatic logic dependsM(instT p, instT c);
        return p.wr && ((c.ua && c.ra == p.rt) || (c.ub && c.rb == p.rt) ||
                        (c.uc && c.rc == p.rt) || (c.wr && c.rt == p.rt));
    endfunction

    function automatic logic [63:0] packFields(instT x);
        return 64'({x.op, x.ra, x.rb, x.rc, x.rt});
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkBit(string name, logic act, logic exp);
        checkOutput(name, 64'(act), 64'(exp));
    endtask

    task automatic driveInputs(instT a, instT b, logic valid, logic fl);
        bus.pair_valid = valid;  bus.flush = fl;
        bus.opcode_in1 = a.op;   bus.ra_in1 = a.ra;   bus.rb_in1 = a.rb;
        bus.rc_in1 = a.rc;       bus.rt_in1 = a.rt;   bus.use_ra_in1 = a.ua;
        bus.use_rb_in1 = a.ub;   bus.use_rc_in1 = a.uc;
        bus.wr_rt_in1 = a.wr;    bus.lat_in1 = a.lat;
        bus.opcode_in2 = b.op;   bus.ra_in2 = b.ra;   bus.rb_in2 = b.rb;
        bus.rc_in2 = b.rc;       bus.rt_in2 = b.rt;   bus.use_ra_in2 = b.ua;
        bus.use_rb_in2 = b.ub;   bus.use_rc_in2 = b.uc;
        bus.wr_rt_in2 = b.wr;    bus.lat_in2 = b.lat;
    endtask

    task automatic modelReset();
        pend.delete();
        shown1 = zeroI;
        shown2 = zeroI;
        for (int i = 0; i < NREG; i++) readyAt[i] = 0;
    endtask

    // Entered at a falling edge: drive, compare against the model, advance the
    // model, and return at the next falling edge.
    task automatic applyStimulus(instT a, instT b, logic valid, logic fl);
        logic e1, e2, eRdy;
        int   nIss;
        instT x;
        driveInputs(a, b, valid, fl);
        #1;
        e1 = 1'b0;
        e2 = 1'b0;
        if (pend.size() == 2) begin
            e1 = !blockedM(pend[0]);
            e2 = e1 && !blockedM(pend[1]) && !dependsM(pend[0], pend[1]);
        end else if (pend.size() == 1) begin
            e2 = !blockedM(pend[0]);
        end
        nIss = int'(e1) + int'(e2);
        eRdy = !fl && (pend.size() == nIss);

        obsI1 = bus.issue1;  obsI2 = bus.issue2;
        obsNop = bus.nop;    obsRdy = bus.pair_ready;
        checkBit("issue1", obsI1, e1);
        checkBit("issue2", obsI2, e2);
        checkBit("nop", obsNop, !(e1 || e2));
        checkBit("pair_ready", obsRdy, eRdy);
        checkOutput("slot1_fields", 64'({bus.opcode_o1, bus.ra_o1, bus.rb_o1, bus.rc_o1, bus.rt_o1}),
                    packFields(shown1));
        checkOutput("slot2_fields", 64'({bus.opcode_o2, bus.ra_o2, bus.rb_o2, bus.rc_o2, bus.rt_o2}),
                    packFields(shown2));

        for (int k = 0; k < nIss; k++) begin
            x = pend.pop_front();
            if (x.wr && x.lat != 0) readyAt[x.rt] = cyc + longint'(x.lat) + 64'sd1;
        end
        if (fl) begin
            pend.delete();
        end else if (valid && eRdy) begin
            pend.push_back(a);
            pend.push_back(b);
            shown1 = a;
            shown2 = b;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        driveInputs(zeroI, zeroI, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkBit("rst_nop", bus.nop, 1'b1);
        checkBit("rst_issue1", bus.issue1, 1'b0);
        checkBit("rst_issue2", bus.issue2, 1'b0);
        checkBit("rst_ready", bus.pair_ready, 1'b1);
        checkOutput("rst_fields", 64'({bus.opcode_o1, bus.rt_o1, bus.opcode_o2, bus.rt_o2}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    initial begin
        instT a, b, c, d, e, f, g, h;
        zeroI = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        driveInputs(zeroI, zeroI, 1'b0, 1'b0);
        #2;
        applyReset();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
            checkBit("idle_nop", obsNop, 1'b1);
            checkBit("idle_ready", obsRdy, 1'b1);
            checkOutput("idle_issue", 64'({obsI1, obsI2}), 64'd0);
        end

        // Independent pair issues together, then a consumer of r5 waits for it.
        a = mk(1, 0, 0, 0, 5, 0, 0, 0, 1, 3);
        b = mk(2, 9, 0, 0, 0, 1, 0, 0, 0, 0);
        c = mk(7, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        d = mk(8, 1, 2, 3, 4, 0, 0, 0, 0, 0);
        applyStimulus(a, b, 1'b1, 1'b0);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("dual_issue", 64'({obsI1, obsI2, obsRdy}), 64'b111);
        applyStimulus(c, d, 1'b1, 1'b0);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("raw1_wait_a", 64'({obsNop, obsRdy}), 64'b10);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("raw1_wait_b", 64'({obsNop, obsRdy}), 64'b10);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("raw1_go", 64'({obsI1, obsI2}), 64'b11);
        idle(4);

        // Slot 2 reads the slot 1 result: split issue, three bubbles, then slot 2.
        e = mk(3, 0, 0, 0, 5, 0, 0, 0, 1, 3);
        f = mk(4, 5, 0, 0, 6, 1, 0, 0, 1, 2);
        applyStimulus(e, f, 1'b1, 1'b0);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("split_first", 64'({obsI1, obsI2}), 64'b10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
            checkOutput("split_bubble", 64'({obsNop, obsRdy}), 64'b10);
        end
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("split_second", 64'({obsI1, obsI2, obsRdy}), 64'b011);
        idle(4);

        // Flush while only slot 2 is pending, with a new pair offered.
        g = mk(11, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        h = mk(12, 2, 2, 2, 2, 0, 0, 0, 0, 0);
        applyStimulus(e, f, 1'b1, 1'b0);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("flush_pre", 64'({obsI1, obsI2}), 64'b10);
        applyStimulus(g, h, 1'b1, 1'b1);
        checkBit("flush_ready", obsRdy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
            checkOutput("flush_empty", 64'({obsNop, obsRdy}), 64'b11);
        end
        checkOutput("flush_kept_op", 64'(bus.opcode_o1), 64'd3);

        // Both slots write r7: slot 2 waits out slot 1's one-cycle latency.
        a = mk(5, 0, 0, 0, 7, 0, 0, 0, 1, 1);
        b = mk(6, 0, 0, 0, 7, 0, 0, 0, 1, 2);
        applyStimulus(a, b, 1'b1, 1'b0);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("waw_first", 64'({obsI1, obsI2}), 64'b10);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkBit("waw_wait", obsNop, 1'b1);
        applyStimulus(zeroI, zeroI, 1'b0, 1'b0);
        checkOutput("waw_second", 64'({obsI1, obsI2}), 64'b01);
        idle(4);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) applyReset();
            applyStimulus(randInst(), randInst(), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
